// File: rtl/dcm_clkgen_ctrl_if.sv
// Frequency-change request channel between the comm/control logic and the
// DCM_CLKGEN controller.
interface dcm_clkgen_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_mult;
  logic [7:0] req_div;
  logic       req_err;

  modport master (
    output req_valid,
    output req_mult,
    output req_div,
    input  req_ready,
    input  req_err
  );

  modport slave (
    input  req_valid,
    input  req_mult,
    input  req_div,
    output req_ready,
    output req_err
  );
endinterface

// File: rtl/dcm_clkgen_ctrl.sv
// Runtime M/D controller for a DCM_CLKGEN: serial PROG programming, LOCKED
// supervision, retry and fallback to the boot frequency.
module dcm_clkgen_ctrl #(
  parameter int OSC_CLOCK_RATE = 25000000,
  parameter int DEFAULT_MULT   = 8,
  parameter int DEFAULT_DIV    = 1,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                     clk_osc_i,
  input  logic                     reset_n_i,
  dcm_clkgen_ctrl_if.slave         req,
  output logic                     progen_o,
  output logic                     progdata_o,
  input  logic                     progdone_i,
  input  logic                     locked_i,
  input  logic                     clkfx_stopped_i,
  output logic                     clk_valid_o,
  output logic [7:0]               cur_mult_o,
  output logic [7:0]               cur_div_o,
  output logic                     busy_o,
  output logic                     fault_o
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
  localparam logic [7:0]    DEF_M       = 8'(DEFAULT_MULT);
  localparam logic [7:0]    DEF_D       = 8'(DEFAULT_DIV);

  // An impossible boot configuration comes out of reset already faulted.
  localparam bit CFG_OK = (OSC_CLOCK_RATE > 0) &&
                          (DEFAULT_MULT >= 2) && (DEFAULT_MULT <= 255) &&
                          (DEFAULT_DIV >= 1) && (DEFAULT_DIV <= 255);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_D,
    S_GAP_D,
    S_LOAD_M,
    S_GAP_M,
    S_GO,
    S_WAIT_DONE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_FAULT
  } state_t;

  state_t        state_q;
  logic [3:0]    bit_cnt_q;
  logic [TW-1:0] timer_q;
  logic [SW-1:0] settle_q;
  logic [RW-1:0] retry_q;
  logic [7:0]    target_mult_q;
  logic [7:0]    target_div_q;
  logic [7:0]    cur_mult_q;
  logic [7:0]    cur_div_q;
  logic          progen_q;
  logic          progdata_q;
  logic          ready_q;
  logic          err_q;
  logic          clk_valid_q;
  logic          busy_q;
  logic          fault_q;

  logic          good;
  logic          timed_out;
  logic          req_legal;
  logic          accept_legal;
  logic          accept_bad;
  logic          fail;
  logic [RW-1:0] retry_inc;
  logic [9:0]    d_word;
  logic [9:0]    m_word;

  assign good         = locked_i && !clkfx_stopped_i;
  assign timed_out    = (timer_q == TIMER_LAST);
  assign req_legal    = (req.req_mult >= 8'd2) && (req.req_div != 8'd0);
  assign accept_legal = req.req_valid && ready_q && req_legal;
  assign accept_bad   = req.req_valid && ready_q && !req_legal;
  assign retry_inc    = (retry_q == '1) ? retry_q : retry_q + 1'b1;
  assign fail         = timed_out &&
                        (((state_q == S_WAIT_DONE) && !progdone_i) ||
                         ((state_q == S_WAIT_LOCK) && !good));

  // Serial words are sent LSB first: address bits {1,0}/{1,1}, then value-1.
  assign d_word = {target_div_q - 8'd1, 1'b0, 1'b1};
  assign m_word = {target_mult_q - 8'd1, 1'b1, 1'b1};

  always_ff @(posedge clk_osc_i) begin
    if (!reset_n_i) begin
      state_q       <= S_LOAD_D;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      settle_q      <= '0;
      retry_q       <= '0;
      target_mult_q <= DEF_M;
      target_div_q  <= DEF_D;
      cur_mult_q    <= DEF_M;
      cur_div_q     <= DEF_D;
      progen_q      <= 1'b0;
      progdata_q    <= 1'b0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      clk_valid_q   <= 1'b0;
      busy_q        <= 1'b1;
      fault_q       <= !CFG_OK;
    end else begin
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
      err_q      <= accept_bad;

      // Each state describes the PROG pins driven during the following cycle.
      case (state_q)
        S_IDLE: begin
          if (!good) begin
            clk_valid_q <= 1'b0;
            if (timed_out) begin
              target_mult_q <= cur_mult_q;
              target_div_q  <= cur_div_q;
              retry_q       <= '0;
              busy_q        <= 1'b1;
              ready_q       <= 1'b0;
              bit_cnt_q     <= '0;
              timer_q       <= '0;
              state_q       <= S_LOAD_D;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end else if (timer_q != '0) begin
            clk_valid_q <= 1'b0;
            settle_q    <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            state_q     <= S_SETTLE;
          end else begin
            clk_valid_q <= 1'b1;
          end
        end
        S_LOAD_D: begin
          progen_q   <= 1'b1;
          progdata_q <= d_word[bit_cnt_q];
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_q <= '0;
            state_q   <= S_GAP_D;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        S_GAP_D: state_q <= S_LOAD_M;
        S_LOAD_M: begin
          progen_q   <= 1'b1;
          progdata_q <= m_word[bit_cnt_q];
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_q <= '0;
            state_q   <= S_GAP_M;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        S_GAP_M: state_q <= S_GO;
        S_GO: begin
          progen_q <= 1'b1;
          timer_q  <= '0;
          state_q  <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (progdone_i) begin
            timer_q <= '0;
            state_q <= S_WAIT_LOCK;
          end else if (!timed_out) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (good) begin
            settle_q <= '0;
            state_q  <= S_SETTLE;
          end else if (!timed_out) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (!good) begin
            settle_q <= '0;
          end else if (settle_q == SETTLE_LAST) begin
            cur_mult_q  <= target_mult_q;
            cur_div_q   <= target_div_q;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            clk_valid_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= S_IDLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_FAULT: ;
        default: state_q <= S_LOAD_D;
      endcase

      // Failed attempt: retry the same target, then fall back to boot values.
      if (fail) begin
        bit_cnt_q <= '0;
        timer_q   <= '0;
        state_q   <= S_LOAD_D;
        if (retry_inc < RETRY_MAX) begin
          retry_q <= retry_inc;
        end else if ((target_mult_q != DEF_M) || (target_div_q != DEF_D)) begin
          target_mult_q <= DEF_M;
          target_div_q  <= DEF_D;
          retry_q       <= '0;
        end else begin
          retry_q <= retry_inc;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          fault_q <= 1'b1;
          state_q <= S_FAULT;
        end
      end

      if (accept_legal) begin
        target_mult_q <= req.req_mult;
        target_div_q  <= req.req_div;
        retry_q       <= '0;
        fault_q       <= 1'b0;
        clk_valid_q   <= 1'b0;
        busy_q        <= 1'b1;
        ready_q       <= 1'b0;
        bit_cnt_q     <= '0;
        timer_q       <= '0;
        state_q       <= S_LOAD_D;
      end
    end
  end

  assign progen_o      = progen_q;
  assign progdata_o    = progdata_q;
  assign req.req_ready = ready_q;
  assign req.req_err   = err_q;
  assign clk_valid_o   = clk_valid_q;
  assign cur_mult_o    = cur_mult_q;
  assign cur_div_o     = cur_div_q;
  assign busy_o        = busy_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_dcm_clkgen_ctrl.sv
// Directed bench for dcm_clkgen_ctrl with a behavioural DCM_CLKGEN model and a
// queue of expected PROG bits (value plus cycle offset within its sequence).
module tb_dcm_clkgen_ctrl;
  localparam int LT = 256;
  localparam int SC = 32;

  typedef struct {
    logic bitVal;
    int   offset;
  } expBit_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       progen;
  logic       progdata;
  logic       progdone = 1'b0;
  logic       mdlLocked = 1'b0;
  logic       forceLow = 1'b0;
  logic       stopped = 1'b0;
  logic       locked;
  logic       clkValid;
  logic [7:0] curMult;
  logic [7:0] curDiv;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;
  expBit_t expQ[$];

  dcm_clkgen_ctrl_if reqIf ();

  assign locked = mdlLocked && !forceLow;

  dcm_clkgen_ctrl #(
    .OSC_CLOCK_RATE(25000000),
    .DEFAULT_MULT  (8),
    .DEFAULT_DIV   (1),
    .LOCK_TIMEOUT  (LT),
    .SETTLE_CYCLES (SC),
    .MAX_RETRIES   (3)
  ) dut (
    .clk_osc_i      (clk),
    .reset_n_i      (resetN),
    .req            (reqIf),
    .progen_o       (progen),
    .progdata_o     (progdata),
    .progdone_i     (progdone),
    .locked_i       (locked),
    .clkfx_stopped_i(stopped),
    .clk_valid_o    (clkValid),
    .cur_mult_o     (curMult),
    .cur_div_o      (curDiv),
    .busy_o         (busy),
    .fault_o        (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushStream(input logic [7:0] m, input logic [7:0] d);
    logic [7:0] dm1;
    logic [7:0] mm1;
    dm1 = d - 8'd1;
    mm1 = m - 8'd1;
    expQ.push_back('{1'b1, 0});
    expQ.push_back('{1'b0, 1});
    for (int i = 0; i < 8; i++) expQ.push_back('{dm1[i], 2 + i});
    expQ.push_back('{1'b1, 11});
    expQ.push_back('{1'b1, 12});
    for (int i = 0; i < 8; i++) expQ.push_back('{mm1[i], 13 + i});
    expQ.push_back('{1'b0, 22});
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] d);
    int n;
    @(negedge clk);
    reqIf.req_valid = 1'b1;
    reqIf.req_mult  = m;
    reqIf.req_div   = d;
    n = 0;
    while (reqIf.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqReady", {31'd0, reqIf.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    reqIf.req_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < maxCycles);
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  // DCM model: decodes M from the PROG stream, pulses PROGDONE three cycles
  // after GO unless M is marked dead, then asserts LOCKED 200 cycles later.
  int         runLen = 0;
  logic [9:0] runBits = '0;
  int         mdlMult = 8;
  int         deadMult = -1;
  bit         allDead = 1'b0;
  int         doneCnt = 0;
  int         lockCnt = 0;

  always @(negedge clk) begin
    if (progen === 1'b1) begin
      if (runLen < 10) runBits[runLen] = progdata;
      runLen++;
      mdlLocked = 1'b0;
      doneCnt = 0;
      lockCnt = 0;
    end else begin
      if (runLen == 10 && runBits[1]) mdlMult = int'(runBits[9:2]) + 1;
      if (runLen == 1) doneCnt = 3;
      runLen = 0;
    end
    progdone = 1'b0;
    if (doneCnt > 0) begin
      doneCnt--;
      if (doneCnt == 0 && !allDead && mdlMult != deadMult) begin
        progdone = 1'b1;
        lockCnt = 200;
      end
    end else if (lockCnt > 0) begin
      lockCnt--;
      if (lockCnt == 0) mdlLocked = 1'b1;
    end
  end

  int      cyc = 0;
  int      streamStart = 0;
  expBit_t monEntry;

  always @(negedge clk) begin
    cyc++;
    if (progen === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedProgen", {31'd0, progen}, 32'd0);
      end else begin
        monEntry = expQ.pop_front();
        if (monEntry.offset == 0) streamStart = cyc;
        checkOutput("progData", {31'd0, progdata}, {31'd0, monEntry.bitVal});
        checkOutput("progOffset", cyc - streamStart, monEntry.offset);
      end
    end
  end

  initial begin
    int n;
    reqIf.req_valid = 1'b0;
    reqIf.req_mult  = 8'd0;
    reqIf.req_div   = 8'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstProgen", {31'd0, progen}, 32'd0);
    checkOutput("rstProgdata", {31'd0, progdata}, 32'd0);
    checkOutput("rstReady", {31'd0, reqIf.req_ready}, 32'd0);
    checkOutput("rstErr", {31'd0, reqIf.req_err}, 32'd0);
    checkOutput("rstClkValid", {31'd0, clkValid}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd1);
    checkOutput("rstFault", {31'd0, fault}, 32'd0);
    checkOutput("rstCurMult", {24'd0, curMult}, 32'd8);
    checkOutput("rstCurDiv", {24'd0, curDiv}, 32'd1);

    $display("[TB] boot programming");
    pushStream(8'd8, 8'd1);
    resetN = 1'b1;
    waitIdle(2000, "bootDone");
    checkOutput("bootClkValid", {31'd0, clkValid}, 32'd1);
    checkOutput("bootCurMult", {24'd0, curMult}, 32'd8);
    checkOutput("bootCurDiv", {24'd0, curDiv}, 32'd1);
    checkOutput("bootReady", {31'd0, reqIf.req_ready}, 32'd1);

    $display("[TB] request M=10 D=1");
    pushStream(8'd10, 8'd1);
    applyStimulus(8'd10, 8'd1);
    @(negedge clk);
    checkOutput("reqClkValidDrop", {31'd0, clkValid}, 32'd0);
    checkOutput("reqBusy", {31'd0, busy}, 32'd1);
    checkOutput("reqReadyDrop", {31'd0, reqIf.req_ready}, 32'd0);
    waitIdle(2000, "req10Done");
    checkOutput("req10CurMult", {24'd0, curMult}, 32'd10);
    checkOutput("req10CurDiv", {24'd0, curDiv}, 32'd1);
    checkOutput("req10ClkValid", {31'd0, clkValid}, 32'd1);

    $display("[TB] illegal requests");
    applyStimulus(8'd1, 8'd1);
    @(negedge clk);
    checkOutput("errPulseM1", {31'd0, reqIf.req_err}, 32'd1);
    @(negedge clk);
    checkOutput("errEndM1", {31'd0, reqIf.req_err}, 32'd0);
    applyStimulus(8'd10, 8'd0);
    @(negedge clk);
    checkOutput("errPulseD0", {31'd0, reqIf.req_err}, 32'd1);
    @(negedge clk);
    checkOutput("errEndD0", {31'd0, reqIf.req_err}, 32'd0);
    checkOutput("errBusy", {31'd0, busy}, 32'd0);
    checkOutput("errCurMult", {24'd0, curMult}, 32'd10);
    checkOutput("errCurDiv", {24'd0, curDiv}, 32'd1);
    checkOutput("errClkValid", {31'd0, clkValid}, 32'd1);

    $display("[TB] short LOCKED glitch");
    forceLow = 1'b1;
    repeat (5) @(negedge clk);
    forceLow = 1'b0;
    n = 5;
    while (clkValid !== 1'b1 && n < 500) begin
      @(negedge clk);
      if (clkValid !== 1'b1) n++;
      if (n == 7) checkOutput("glitchBusy", {31'd0, busy}, 32'd1);
    end
    checkOutput("glitchLowCycles", n, 5 + SC);
    checkOutput("glitchCurMult", {24'd0, curMult}, 32'd10);

    $display("[TB] long LOCKED loss");
    pushStream(8'd10, 8'd1);
    @(negedge clk);
    forceLow = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 2 * LT);
    checkOutput("lossTimeout", n, LT);
    forceLow = 1'b0;
    waitIdle(2000, "lossReprogDone");
    checkOutput("lossCurMult", {24'd0, curMult}, 32'd10);
    checkOutput("lossClkValid", {31'd0, clkValid}, 32'd1);

    $display("[TB] dead M=12 with fallback");
    deadMult = 12;
    for (int i = 0; i < 3; i++) pushStream(8'd12, 8'd1);
    pushStream(8'd8, 8'd1);
    applyStimulus(8'd12, 8'd1);
    waitIdle(5000, "fallbackDone");
    checkOutput("fallbackCurMult", {24'd0, curMult}, 32'd8);
    checkOutput("fallbackCurDiv", {24'd0, curDiv}, 32'd1);
    checkOutput("fallbackFault", {31'd0, fault}, 32'd0);
    checkOutput("fallbackClkValid", {31'd0, clkValid}, 32'd1);

    $display("[TB] dead DCM, fault");
    allDead = 1'b1;
    for (int i = 0; i < 3; i++) pushStream(8'd12, 8'd1);
    for (int i = 0; i < 3; i++) pushStream(8'd8, 8'd1);
    applyStimulus(8'd12, 8'd1);
    waitIdle(5000, "faultReached");
    checkOutput("faultFlag", {31'd0, fault}, 32'd1);
    checkOutput("faultReady", {31'd0, reqIf.req_ready}, 32'd1);
    checkOutput("faultClkValid", {31'd0, clkValid}, 32'd0);
    checkOutput("faultCurMult", {24'd0, curMult}, 32'd8);

    $display("[TB] recover from fault with M=9 D=3");
    allDead = 1'b0;
    deadMult = -1;
    pushStream(8'd9, 8'd3);
    applyStimulus(8'd9, 8'd3);
    @(negedge clk);
    checkOutput("faultCleared", {31'd0, fault}, 32'd0);
    waitIdle(2000, "recoverDone");
    checkOutput("recoverCurMult", {24'd0, curMult}, 32'd9);
    checkOutput("recoverCurDiv", {24'd0, curDiv}, 32'd3);

    $display("[TB] reset during LOAD_M");
    pushStream(8'd10, 8'd2);
    applyStimulus(8'd10, 8'd2);
    n = 0;
    while (expQ.size() > 8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midLoadMReached", {31'd0, expQ.size() <= 8}, 32'd1);
    @(posedge clk);
    #1;
    resetN = 1'b0;
    @(posedge clk);
    #1;
    expQ.delete();
    pushStream(8'd8, 8'd1);
    @(negedge clk);
    checkOutput("midRstProgen", {31'd0, progen}, 32'd0);
    checkOutput("midRstBusy", {31'd0, busy}, 32'd1);
    checkOutput("midRstCurMult", {24'd0, curMult}, 32'd8);
    checkOutput("midRstCurDiv", {24'd0, curDiv}, 32'd1);
    @(negedge clk);
    resetN = 1'b1;
    waitIdle(2000, "rebootDone");
    checkOutput("rebootCurMult", {24'd0, curMult}, 32'd8);
    checkOutput("rebootClkValid", {31'd0, clkValid}, 32'd1);

    repeat (5) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
